ysyx_23060075_csr_trap: RTL and testbench
=========================================

# ysyx_23060075_csr_trap

Machine-mode CSR file with trap entry/exit sequencing and 64-bit performance counters. Sits beside the regfile in the execute stage and serves Zicsr reads and writes plus ecall/exception entry and mret return. Supplies the trap vector and the return PC to next-PC selection.

## Interface
- XLEN, 32: register width; only 32 is supported, because counters are split into low/high halves.
- HART_ID, 0: constant value returned by mhartid.
- RESET_MTVEC, 0: reset value of mtvec; bits [1:0] are forced to 0.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- csr_addr  in  12  CSR address.
- csr_op  in  2  operation: 00 none, 01 RW, 10 RS (set bits), 11 RC (clear bits).
- csr_wdata  in  XLEN  write value (RW) or bit mask (RS/RC).
- csr_rdata  out  XLEN  current value of the addressed CSR; combinational.
- csr_illegal  out  1  access is illegal; combinational.
- trap_valid  in  1  take a trap this cycle.
- trap_cause  in  XLEN  value to write into mcause.
- trap_pc  in  XLEN  PC of the trapping instruction.
- mret_valid  in  1  execute mret this cycle.
- instret_inc  in  1  one instruction retires this cycle.
- trap_vector  out  XLEN  mtvec with bits [1:0] cleared; direct mode only.
- mepc_out  out  XLEN  current mepc, used as the mret target.

## Operation
- CSR map:
  - mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342: read/write.
  - mhartid 0xF14: read-only.
  - Counters: mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82.
- Write value:
  - RW writes wdata.
  - RS writes old | wdata.
  - RC writes old & ~wdata.
  - RS/RC with wdata==0 is not a write.
- csr_illegal=1 when csr_op!=00 and either the address is unmapped, or a write targets mhartid. An illegal access suppresses the write; csr_rdata reads 0.
- mstatus fields:
  - Only MIE[3] and MPIE[7] are stored.
  - MPP[12:11] always reads 11.
  - All other bits read 0 and ignore writes.
- Field masks:
  - mtvec bits [1:0] and mepc bits [1:0] are forced to 0 on every write.
  - mcause is fully writable.
- Trap entry (trap_valid=1): mepc<=trap_pc&~3, mcause<=trap_cause, MPIE<=MIE, MIE<=0.
- mret (mret_valid=1): MIE<=MPIE, MPIE<=1. mepc is unchanged.
- Priority in one cycle: trap > mret > CSR write. A lower-priority action is dropped entirely, with no partial update; csr_illegal still reflects the access.
- mcycle: 64-bit, +1 every cycle out of reset.
- minstret: 64-bit, +1 when instret_inc=1.
- Counter write vs increment: a write to either half loads that half with the write value and suppresses the increment of the whole 64-bit counter that cycle. The other half holds.
- Counters wrap from 0xFFFF_FFFF_FFFF_FFFF to 0. The low-half carry into the high half happens in the same cycle.

## Timing
- Reads are combinational and return the pre-edge value. A read-modify-write completes in one cycle.
- All updates are visible on csr_rdata, trap_vector and mepc_out in the cycle after the edge.
- Reset values:
  - mstatus 0x0000_1800.
  - mtvec RESET_MTVEC&~3.
  - mepc, mcause, mscratch 0.
  - mcycle, minstret 0.
  - Outputs follow from these values.
- Reset is asynchronous. Asserting rst mid-operation clears state immediately; no pending update survives.
- The first mcycle increment occurs on the first rising edge after rst deasserts.

## Configuration
- YSYX_23060075_CSR_COUNTER_EN defined: mcycle, mcycleh, minstret and minstreth are implemented as described.
- Not defined:
  - The counter registers are not synthesised.
  - The four counter addresses are unmapped, so accesses raise csr_illegal and read 0.
  - instret_inc is ignored.

## Test plan
- Reset, then read every mapped CSR: mstatus=0x1800, mtvec=RESET_MTVEC, mhartid=HART_ID, all others 0; csr_illegal=0.
- RW mtvec=0x8000_0007, then RS mscratch=0xF0, then RC mscratch=0x30: mtvec reads 0x8000_0004, mscratch reads 0xC0.
- Set MIE, then trap_valid with trap_pc=0x8000_0102 and cause=11: mepc=0x8000_0100, mcause=11, mstatus=0x1880. Then mret: mstatus=0x1888.
- Same cycle: trap_valid + mret_valid + RW mscratch=5: only trap effects occur; mscratch unchanged.
- RW mhartid, and RW to address 0x7C0: csr_illegal=1, no state change; RS mhartid with wdata=0 is legal and returns HART_ID.
- (COUNTER_EN) RW mcycle=0xFFFF_FFFE, wait 2 cycles: mcycle=0, mcycleh=1. minstret counts only cycles with instret_inc=1.

Source files
------------

// File: rtl/ysyx_23060075_csr_trap.sv
// Machine-mode CSR file with trap entry/mret and 64-bit mcycle/minstret; reads combinational, writes land on the next edge.
// Counters exist only when YSYX_23060075_CSR_COUNTER_EN is defined; otherwise their addresses are unmapped.
module ysyx_23060075_csr_trap #(
   parameter int               XLEN        = 32,
   parameter logic [XLEN-1:0]  HART_ID     = '0,
   parameter logic [XLEN-1:0]  RESET_MTVEC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [11:0]     csr_addr,
   input  logic [1:0]      csr_op,
   input  logic [XLEN-1:0] csr_wdata,
   output logic [XLEN-1:0] csr_rdata,
   output logic            csr_illegal,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_cause,
   input  logic [XLEN-1:0] trap_pc,
   input  logic            mret_valid,
   input  logic            instret_inc,
   output logic [XLEN-1:0] trap_vector,
   output logic [XLEN-1:0] mepc_out
);
   localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
   localparam logic [11:0] ADDR_MTVEC     = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
   localparam logic [11:0] ADDR_MEPC      = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
   localparam logic [11:0] ADDR_MHARTID   = 12'hF14;
   localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
   localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
   localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

   localparam logic [1:0] OP_NONE = 2'b00;
   localparam logic [1:0] OP_RW   = 2'b01;
   localparam logic [1:0] OP_RS   = 2'b10;
   localparam logic [1:0] OP_RC   = 2'b11;

   logic            mie, mpie;
   logic [XLEN-1:0] mtvec, mscratch, mepc, mcause;
   logic [XLEN-1:0] mstatus_val, rd_val, wr_val;
   logic            mapped, is_write, wr_en;

   assign mstatus_val = XLEN'({2'b11, 3'b000, mpie, 3'b000, mie, 3'b000});

`ifdef YSYX_23060075_CSR_COUNTER_EN
   logic [2*XLEN-1:0] mcycle, minstret;
`endif

   always_comb begin
      rd_val = '0;
      mapped = 1'b1;
      case (csr_addr)
         ADDR_MSTATUS:   rd_val = mstatus_val;
         ADDR_MTVEC:     rd_val = mtvec;
         ADDR_MSCRATCH:  rd_val = mscratch;
         ADDR_MEPC:      rd_val = mepc;
         ADDR_MCAUSE:    rd_val = mcause;
         ADDR_MHARTID:   rd_val = HART_ID;
`ifdef YSYX_23060075_CSR_COUNTER_EN
         ADDR_MCYCLE:    rd_val = mcycle[XLEN-1:0];
         ADDR_MCYCLEH:   rd_val = mcycle[2*XLEN-1:XLEN];
         ADDR_MINSTRET:  rd_val = minstret[XLEN-1:0];
         ADDR_MINSTRETH: rd_val = minstret[2*XLEN-1:XLEN];
`endif
         default:        mapped = 1'b0;
      endcase
   end

   // RS/RC with an all-zero mask is a pure read, so it is legal even on mhartid.
   assign is_write    = (csr_op == OP_RW) || (csr_wdata != '0);
   assign csr_illegal = (csr_op != OP_NONE) &&
                        (!mapped || ((csr_addr == ADDR_MHARTID) && is_write));
   assign csr_rdata   = csr_illegal ? '0 : rd_val;

   always_comb begin
      case (csr_op)
         OP_RW:   wr_val = csr_wdata;
         OP_RS:   wr_val = rd_val | csr_wdata;
         OP_RC:   wr_val = rd_val & ~csr_wdata;
         default: wr_val = rd_val;
      endcase
   end

   assign wr_en = (csr_op != OP_NONE) && is_write && !csr_illegal &&
                  !trap_valid && !mret_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mie      <= 1'b0;
         mpie     <= 1'b0;
         mtvec    <= {RESET_MTVEC[XLEN-1:2], 2'b00};
         mscratch <= '0;
         mepc     <= '0;
         mcause   <= '0;
      end else if (trap_valid) begin
         mepc   <= {trap_pc[XLEN-1:2], 2'b00};
         mcause <= trap_cause;
         mpie   <= mie;
         mie    <= 1'b0;
      end else if (mret_valid) begin
         mie  <= mpie;
         mpie <= 1'b1;
      end else if (wr_en) begin
         case (csr_addr)
            ADDR_MSTATUS: begin
               mie  <= wr_val[3];
               mpie <= wr_val[7];
            end
            ADDR_MTVEC:    mtvec    <= {wr_val[XLEN-1:2], 2'b00};
            ADDR_MSCRATCH: mscratch <= wr_val;
            ADDR_MEPC:     mepc     <= {wr_val[XLEN-1:2], 2'b00};
            ADDR_MCAUSE:   mcause   <= wr_val;
            default: ;
         endcase
      end
   end

`ifdef YSYX_23060075_CSR_COUNTER_EN
   // A write to either half freezes the whole counter for that cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcycle   <= '0;
         minstret <= '0;
      end else begin
         if (wr_en && csr_addr == ADDR_MCYCLE)
            mcycle[XLEN-1:0] <= wr_val;
         else if (wr_en && csr_addr == ADDR_MCYCLEH)
            mcycle[2*XLEN-1:XLEN] <= wr_val;
         else
            mcycle <= mcycle + 1'b1;

         if (wr_en && csr_addr == ADDR_MINSTRET)
            minstret[XLEN-1:0] <= wr_val;
         else if (wr_en && csr_addr == ADDR_MINSTRETH)
            minstret[2*XLEN-1:XLEN] <= wr_val;
         else if (instret_inc)
            minstret <= minstret + 1'b1;
      end
   end
`else
   logic unused_instret_inc;
   assign unused_instret_inc = instret_inc;
`endif

   assign trap_vector = mtvec;
   assign mepc_out    = mepc;
endmodule

// File: tb/tb_ysyx_23060075_csr_trap.sv
// Directed bench for ysyx_23060075_csr_trap; counter checks follow YSYX_23060075_CSR_COUNTER_EN.
module tb_ysyx_23060075_csr_trap;
   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] csr_addr;
   logic [1:0]  csr_op;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        csr_illegal;
   logic        trap_valid;
   logic [31:0] trap_cause;
   logic [31:0] trap_pc;
   logic        mret_valid;
   logic        instret_inc;
   logic [31:0] trap_vector;
   logic [31:0] mepc_out;

   int total = 0;
   int bad   = 0;

   ysyx_23060075_csr_trap #(
      .XLEN(32), .HART_ID(32'h0000_0005), .RESET_MTVEC(32'h8000_0003)
   ) dut (
      .clk(clk), .rst(rst),
      .csr_addr(csr_addr), .csr_op(csr_op), .csr_wdata(csr_wdata),
      .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
      .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
      .mret_valid(mret_valid), .instret_inc(instret_inc),
      .trap_vector(trap_vector), .mepc_out(mepc_out)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and drop the one-shot controls.
   task automatic step();
      @(posedge clk);
      #1;
      csr_op     = 2'b00;
      trap_valid = 1'b0;
      mret_valid = 1'b0;
   endtask

   task automatic rd(input logic [11:0] a, output logic [31:0] v, output logic ill);
      csr_addr = a;
      csr_op   = 2'b00;
      #1;
      v   = csr_rdata;
      ill = csr_illegal;
   endtask

   task automatic drive(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
      csr_op    = op;
      csr_addr  = a;
      csr_wdata = d;
      #1;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      logic        ill;
      logic [11:0] addrs [6];
      logic [31:0] exp   [6];
      addrs = '{12'h300, 12'h305, 12'hF14, 12'h340, 12'h341, 12'h342};
      exp   = '{32'h0000_1800, 32'h8000_0000, 32'h0000_0005, 32'h0, 32'h0, 32'h0};
      for (int i = 0; i < 6; i++) begin
         rd(addrs[i], v, ill);
         total++;
         if (v !== exp[i] || ill !== 1'b0) begin
            $display("FAIL reset_read addr=%h got=%h ill=%b exp=%h ill=0", addrs[i], v, ill, exp[i]);
            bad++;
         end
      end
      total++;
      if (trap_vector !== 32'h8000_0000 || mepc_out !== 32'h0) begin
         $display("FAIL reset_outputs tvec=%h mepc=%h exp 80000000/0", trap_vector, mepc_out);
         bad++;
      end
   endtask

   task automatic test_rw_rs_rc();
      logic [31:0] v;
      logic        ill;
      drive(2'b01, 12'h305, 32'h8000_0007); step();
      drive(2'b10, 12'h340, 32'h0000_00F0); step();
      drive(2'b11, 12'h340, 32'h0000_0030);
      total++;
      if (csr_rdata !== 32'h0000_00F0) begin
         $display("FAIL rc_preedge_read got=%h exp=000000f0", csr_rdata);
         bad++;
      end
      step();
      rd(12'h305, v, ill);
      total++;
      if (v !== 32'h8000_0004 || trap_vector !== 32'h8000_0004) begin
         $display("FAIL mtvec_rw got=%h tvec=%h exp=80000004", v, trap_vector);
         bad++;
      end
      rd(12'h340, v, ill);
      total++;
      if (v !== 32'h0000_00C0) begin
         $display("FAIL mscratch_rs_rc got=%h exp=000000c0", v);
         bad++;
      end
   endtask

   task automatic test_trap_mret();
      logic [31:0] v;
      logic        ill;
      drive(2'b10, 12'h300, 32'h0000_0008); step();
      rd(12'h300, v, ill);
      total++;
      if (v !== 32'h0000_1808) begin
         $display("FAIL set_mie got=%h exp=00001808", v);
         bad++;
      end
      trap_valid = 1'b1; trap_pc = 32'h8000_0102; trap_cause = 32'd11;
      step();
      rd(12'h341, v, ill);
      total++;
      if (v !== 32'h8000_0100 || mepc_out !== 32'h8000_0100) begin
         $display("FAIL trap_mepc got=%h out=%h exp=80000100", v, mepc_out);
         bad++;
      end
      rd(12'h342, v, ill);
      total++;
      if (v !== 32'd11) begin
         $display("FAIL trap_mcause got=%h exp=0000000b", v);
         bad++;
      end
      rd(12'h300, v, ill);
      total++;
      if (v !== 32'h0000_1880) begin
         $display("FAIL trap_mstatus got=%h exp=00001880", v);
         bad++;
      end
      mret_valid = 1'b1;
      step();
      rd(12'h300, v, ill);
      total++;
      if (v !== 32'h0000_1888 || mepc_out !== 32'h8000_0100) begin
         $display("FAIL mret_mstatus got=%h mepc=%h exp=00001888/80000100", v, mepc_out);
         bad++;
      end
   endtask

   task automatic test_priority();
      logic [31:0] v;
      logic        ill;
      trap_valid = 1'b1; mret_valid = 1'b1;
      trap_pc = 32'h0000_0203; trap_cause = 32'h8000_0003;
      drive(2'b01, 12'h340, 32'h0000_0005);
      step();
      rd(12'h340, v, ill);
      total++;
      if (v !== 32'h0000_00C0) begin
         $display("FAIL prio_mscratch got=%h exp=000000c0", v);
         bad++;
      end
      rd(12'h300, v, ill);
      total++;
      if (v !== 32'h0000_1880 || mepc_out !== 32'h0000_0200) begin
         $display("FAIL prio_trap got=%h mepc=%h exp=00001880/00000200", v, mepc_out);
         bad++;
      end
      rd(12'h342, v, ill);
      total++;
      if (v !== 32'h8000_0003) begin
         $display("FAIL prio_mcause got=%h exp=80000003", v);
         bad++;
      end
      mret_valid = 1'b1;
      drive(2'b01, 12'h340, 32'h0000_0009);
      step();
      rd(12'h340, v, ill);
      total++;
      if (v !== 32'h0000_00C0) begin
         $display("FAIL mret_drops_write got=%h exp=000000c0", v);
         bad++;
      end
      rd(12'h300, v, ill);
      total++;
      if (v !== 32'h0000_1888) begin
         $display("FAIL mret_over_write got=%h exp=00001888", v);
         bad++;
      end
      trap_valid = 1'b1; trap_pc = 32'h0000_0300; trap_cause = 32'd2;
      drive(2'b01, 12'hF14, 32'h0000_0001);
      total++;
      if (csr_illegal !== 1'b1) begin
         $display("FAIL prio_illegal got=%b exp=1", csr_illegal);
         bad++;
      end
      step();
   endtask

   task automatic test_illegal();
      logic [31:0] v;
      logic        ill;
      drive(2'b01, 12'hF14, 32'h0000_1234);
      total++;
      if (csr_illegal !== 1'b1 || csr_rdata !== 32'h0) begin
         $display("FAIL rw_mhartid ill=%b rdata=%h exp=1/0", csr_illegal, csr_rdata);
         bad++;
      end
      step();
      drive(2'b01, 12'h7C0, 32'h0000_0055);
      total++;
      if (csr_illegal !== 1'b1 || csr_rdata !== 32'h0) begin
         $display("FAIL rw_unmapped ill=%b rdata=%h exp=1/0", csr_illegal, csr_rdata);
         bad++;
      end
      step();
      drive(2'b10, 12'hF14, 32'h0);
      total++;
      if (csr_illegal !== 1'b0 || csr_rdata !== 32'h5) begin
         $display("FAIL rs0_mhartid ill=%b rdata=%h exp=0/5", csr_illegal, csr_rdata);
         bad++;
      end
      drive(2'b11, 12'hF14, 32'h0000_0001);
      total++;
      if (csr_illegal !== 1'b1) begin
         $display("FAIL rc1_mhartid ill=%b exp=1", csr_illegal);
         bad++;
      end
      step();
      rd(12'h7C0, v, ill);
      total++;
      if (ill !== 1'b0 || v !== 32'h0) begin
         $display("FAIL none_op_unmapped ill=%b rdata=%h exp=0/0", ill, v);
         bad++;
      end
      rd(12'hF14, v, ill);
      total++;
      if (v !== 32'h5) begin
         $display("FAIL mhartid_after got=%h exp=5", v);
         bad++;
      end
   endtask

   task automatic test_counters();
      logic [31:0] v, vh;
      logic        ill;
`ifdef YSYX_23060075_CSR_COUNTER_EN
      drive(2'b01, 12'hB00, 32'hFFFF_FFFE); step();
      rd(12'hB00, v, ill);
      rd(12'hB80, vh, ill);
      total++;
      if (v !== 32'hFFFF_FFFE || vh !== 32'h0) begin
         $display("FAIL mcycle_load got=%h_%h exp=00000000_fffffffe", vh, v);
         bad++;
      end
      step(); step();
      rd(12'hB00, v, ill);
      rd(12'hB80, vh, ill);
      total++;
      if (v !== 32'h0 || vh !== 32'h1) begin
         $display("FAIL mcycle_carry got=%h_%h exp=00000001_00000000", vh, v);
         bad++;
      end
      drive(2'b01, 12'hB02, 32'h0); step();
      for (int i = 0; i < 4; i++) begin
         instret_inc = (i != 1);
         step();
      end
      instret_inc = 1'b0;
      rd(12'hB02, v, ill);
      total++;
      if (v !== 32'd3) begin
         $display("FAIL minstret_count got=%h exp=00000003", v);
         bad++;
      end
      instret_inc = 1'b1;
      drive(2'b01, 12'hB82, 32'h0000_0007); step();
      instret_inc = 1'b0;
      rd(12'hB02, v, ill);
      rd(12'hB82, vh, ill);
      total++;
      if (v !== 32'd3 || vh !== 32'd7) begin
         $display("FAIL minstreth_write got=%h_%h exp=00000007_00000003", vh, v);
         bad++;
      end
`else
      instret_inc = 1'b1;
      drive(2'b01, 12'hB00, 32'h0000_0010);
      total++;
      if (csr_illegal !== 1'b1 || csr_rdata !== 32'h0) begin
         $display("FAIL mcycle_absent ill=%b rdata=%h exp=1/0", csr_illegal, csr_rdata);
         bad++;
      end
      step();
      drive(2'b10, 12'hB82, 32'h0000_0001);
      total++;
      if (csr_illegal !== 1'b1 || csr_rdata !== 32'h0) begin
         $display("FAIL minstreth_absent ill=%b rdata=%h exp=1/0", csr_illegal, csr_rdata);
         bad++;
      end
      step();
      instret_inc = 1'b0;
      rd(12'hB02, v, ill);
      rd(12'hB80, vh, ill);
      total++;
      if (v !== 32'h0 || vh !== 32'h0) begin
         $display("FAIL counter_read_absent got=%h/%h exp=0/0", v, vh);
         bad++;
      end
`endif
   endtask

   task automatic test_async_reset();
      logic [31:0] v;
      logic        ill;
      drive(2'b01, 12'h340, 32'hDEAD_BEEF);
      #1 rst = 1'b1;
      #1;
      total++;
      if (csr_rdata !== 32'h0 || mepc_out !== 32'h0 || trap_vector !== 32'h8000_0000) begin
         $display("FAIL async_reset scratch=%h mepc=%h tvec=%h exp=0/0/80000000",
                  csr_rdata, mepc_out, trap_vector);
         bad++;
      end
      csr_op = 2'b00;
      rd(12'h300, v, ill);
      total++;
      if (v !== 32'h0000_1800) begin
         $display("FAIL async_reset_mstatus got=%h exp=00001800", v);
         bad++;
      end
      @(negedge clk);
      rst = 1'b0;
      step();
      rd(12'h340, v, ill);
      total++;
      if (v !== 32'h0) begin
         $display("FAIL post_reset_scratch got=%h exp=0", v);
         bad++;
      end
   endtask

   initial begin
      rst = 1'b1;
      csr_addr = '0; csr_op = 2'b00; csr_wdata = '0;
      trap_valid = 1'b0; trap_cause = '0; trap_pc = '0;
      mret_valid = 1'b0; instret_inc = 1'b0;
      #2;
      test_reset();
      #10 rst = 1'b0;
      step();
      test_rw_rs_rc();
      test_trap_mret();
      test_priority();
      test_illegal();
      test_counters();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
